// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, the
// queue entry layout and the byte stride between sequential instructions.
package fetch_pkg;

   localparam int unsigned DEF_ADDR_W  = 32;
   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned INSTR_BYTES = DEF_DATA_W / 8;
   localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

   // Layout of one prefetch queue entry at the default widths.
   typedef struct packed {
      logic [DEF_DATA_W-1:0] instr;
      logic [DEF_ADDR_W-1:0] pc;
   } fq_entry_t;

   function automatic int unsigned instr_bytes(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read and a synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is accepted only when the head leaves the same cycle.
   assign do_pop  = pop && (cnt != '0);
   assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign count = cnt;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a prefetch queue in front of a variable-latency,
// in-order instruction memory; redirects flush the queue and drop stale replies.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = DEF_ADDR_W,
   parameter int unsigned        DATA_W   = DEF_DATA_W,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
   input  logic                clk,
   input  logic                reset,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_addr,
   output logic                instr_valid,
   output logic [DATA_W-1:0]   instr,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic [ADDR_W-1:0]   instr_pc4,
   input  logic                instr_ready
);

   localparam int unsigned CW   = $clog2(DEPTH) + 1;
   localparam int unsigned SW   = CW + 1;
   localparam int unsigned STEP = instr_bytes(DATA_W);

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   logic [ADDR_W-1:0] fetch_pc;
   logic [CW-1:0]     count;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     discard;
   logic [SW-1:0]     credits_used;
   logic              issue;
   logic              rsp;
   logic              keep;
   logic              pop;
   logic [ADDR_W-1:0] rsp_addr;
   entry_t            wr_entry;
   entry_t            head;
   logic              iq_empty;
   logic              iq_full;
   logic              aq_empty;
   logic              aq_full;

   // Every queued word and every in-flight request holds one credit, so a reply always has room.
   assign credits_used = SW'(count) + SW'(outstanding);
   assign mem_req      = !reset && !redirect && (credits_used < SW'(DEPTH));
   assign mem_addr     = fetch_pc;
   assign issue        = mem_req && mem_gnt;

   assign rsp         = mem_rvalid && !aq_empty;
   assign keep        = rsp && !redirect && (discard == '0);
   assign instr_valid = !reset && !iq_empty;
   assign pop         = instr_valid && instr_ready && !redirect;

   // Addresses of in-flight requests; its occupancy is the outstanding count.
   sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_addr_q (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .push  (issue),
      .wdata (fetch_pc),
      .pop   (rsp),
      .rdata (rsp_addr),
      .empty (aq_empty),
      .full  (aq_full),
      .count (outstanding)
   );

   assign wr_entry = '{instr: mem_rdata, pc: rsp_addr};

   sync_fifo #(.WIDTH(DATA_W + ADDR_W), .DEPTH(DEPTH)) u_instr_q (
      .clk   (clk),
      .reset (reset),
      .clear (redirect),
      .push  (keep),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .empty (iq_empty),
      .full  (iq_full),
      .count (count)
   );

   // Fetch pointer and the number of stale replies still to be dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_addr;
         discard  <= outstanding - CW'(rsp);
      end else begin
         if (issue) fetch_pc <= fetch_pc + ADDR_W'(STEP);
         if (rsp && (discard != '0)) discard <= discard - CW'(1);
      end
   end

   assign instr     = head.instr;
   assign instr_pc  = head.pc;
   assign instr_pc4 = head.pc + ADDR_W'(STEP);

   rsp_without_request: assert property (@(posedge clk) disable iff (reset)
      !(mem_rvalid && aq_empty));
   queue_overflow: assert property (@(posedge clk) disable iff (reset)
      !(keep && iq_full && !pop));
   request_overflow: assert property (@(posedge clk) disable iff (reset)
      !(issue && aq_full));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the B32P fetch stage: a standalone instruction fetch unit with a prefetch queue, serving a variable-latency instruction memory over a request/grant/response handshake.
- Issues sequential fetch addresses, buffers returned words with their PC, and presents them to decode over valid/ready.
- Handles redirects (jump, branch, halt) by flushing the queue and discarding responses still in flight.

Parameters:
ADDR_W, 32, address and PC width
DATA_W, 32, instruction width; must be a multiple of 8
DEPTH, 4, queue entries and also the maximum number of outstanding requests; power of 2, at least 2
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mem_req  out  1  fetch request valid
mem_addr  out  ADDR_W  fetch address
mem_gnt  in  1  memory accepts the request this cycle
mem_rvalid  in  1  response valid; responses return in order
mem_rdata  in  DATA_W  response data
redirect  in  1  flush and restart fetch; asserted by the MEM stage for jump, branch-taken or halt
redirect_addr  in  ADDR_W  new fetch address
instr_valid  out  1  queue head is valid
instr  out  DATA_W  head instruction
instr_pc  out  ADDR_W  head instruction address
instr_pc4  out  ADDR_W  instr_pc + DATA_W/8
instr_ready  in  1  decode consumes the head (equivalent to not stall_FE)

Behaviour:
- Reset: synchronous, active-high; takes priority over every other input.
  - Reset values: fetch_pc = RESET_PC; count, outstanding and discard = 0.
  - During reset: mem_req = 0 and instr_valid = 0.
  - In the first cycle after reset, mem_req = 1 with mem_addr = RESET_PC.
- Credit rule:
  - mem_req = !reset && !redirect && (count + outstanding < DEPTH). This is combinational.
  - mem_addr = fetch_pc.
  - mem_req stays asserted until granted; mem_addr does not change while waiting.
- Issue:
  - Fires when mem_req && mem_gnt.
  - On issue: fetch_pc += DATA_W/8, wrapping modulo 2^ADDR_W, and outstanding += 1.
  - A request queue records the address of each in-flight request.
- Response, when mem_rvalid:
  - outstanding -= 1.
  - If discard > 0: discard -= 1 and the word is dropped.
  - Otherwise {mem_rdata, addr} is written to the queue tail. The entry is visible at the head no earlier than the next cycle; there is no bypass.
- Minimum latency: grant to instr_valid = memory latency + 1 cycle.
- Output:
  - First-word-fall-through.
  - A pop happens when instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- Full queue: count = DEPTH cannot occur with a response pending, because credits guarantee space. No response is ever dropped for lack of space.
- Redirect, in the cycle it is asserted:
  - count <= 0; any pop that cycle is ignored.
  - fetch_pc <= redirect_addr.
  - mem_req = 0.
  - discard <= outstanding - mem_rvalid, i.e. all requests still in flight after this cycle.
  - A response arriving in the redirect cycle is dropped.
  - instr_valid = 0 from the next cycle until a post-redirect word arrives.
- Back-to-back redirects: the last one wins; discard is recomputed each time.
- Halt: redirect to the same address; the fetch repeats indefinitely.
- Protocol errors:
  - mem_rvalid with outstanding = 0 is ignored. An assertion flags it in simulation.
  - mem_gnt without mem_req is ignored.
- Counter widths: count, outstanding and discard are $clog2(DEPTH)+1 bits. They never exceed DEPTH.

Decomposition:
- Shared package `fetch_pkg`:
  - INSTR_BYTES = DATA_W/8.
  - The fetch queue entry struct {instr, pc}.
  - The RESET_PC default.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH):
  - Synchronous clear and FWFT read.
  - Instantiated twice: once for the instruction queue, once for the in-flight address queue, which is cleared by reset only.
- Top-level logic: credit counter, discard counter, fetch_pc register.

Test Plan:
- Zero-wait memory (gnt always 1, rvalid one cycle after gnt), ready always 1, RESET_PC 0 -> instr_pc = 0, 4, 8, 12… on consecutive cycles after the initial fill; instr_pc4 = instr_pc + 4.
- ready held 0 for 10 cycles with DEPTH = 4 -> exactly 4 grants, then mem_req = 0 and no further grants; ready = 1 -> entries for PCs 0, 4, 8, 12 drain in order and fetching resumes at 16.
- 3 requests outstanding with latency 5, redirect to 0x100 -> the 3 late responses are dropped; the first instr_valid shows instr_pc = 0x100.
- redirect in the same cycle as rvalid with 2 outstanding -> discard = 1; the next response is dropped and the following one is 0x100's word.
- Random gnt/rvalid delays of 0–7 cycles with random ready over 10k cycles -> the instr_pc sequence is contiguous between redirects, instr matches the memory model, and no word is lost or duplicated.
- RESET_PC = 0xFFFFFFF8 -> instr_pc = 0xFFFFFFF8, 0xFFFFFFFC, 0x0; reset asserted mid-burst -> mem_req = 0 and instr_valid = 0 next cycle, and after release fetching restarts at RESET_PC.
